// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_hold.sv
// Captures the in-flight instruction word on the first stall edge, because the
// synchronous memory moves on to mem[pc] while decode is stalled.
module fetch_skid_hold
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic        f_valid,
  input  logic [31:0] mem_instr,
  output logic [31:0] if_instr
);

  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;

  always_comb begin
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;
    if (redirect) begin
      hold_valid_d = 1'b0;
    end else if (stall) begin
      // Only the first stall edge sees the word belonging to f_pc.
      if (!hold_valid_q) begin
        hold_instr_d = mem_instr;
        hold_valid_d = f_valid;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_instr_q <= NOP_INSTR;
      hold_valid_q <= 1'b0;
    end else begin
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign if_instr = !f_valid     ? NOP_INSTR    :
                    hold_valid_q ? hold_instr_q : mem_instr;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, pairs the one-cycle-latency memory word with its
// address, and handles stall and branch/jump redirect with squash.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        f_valid_q, f_valid_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    f_valid_d  = f_valid_q;
    misalign_d = 1'b0;
    if (redirect) begin
      // The word memory captures at this edge is on the wrong path; squash it.
      pc_d       = align_addr(redirect_target);
      f_pc_d     = pc_q;
      f_valid_d  = 1'b0;
      misalign_d = |redirect_target[1:0];
    end else if (!stall) begin
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      pc_d      = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      f_pc_q     <= RESET_PC;
      f_valid_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      f_valid_q  <= f_valid_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_skid_hold u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .redirect (redirect),
    .f_valid  (f_valid_q),
    .mem_instr(mem_instr),
    .if_instr (if_instr)
  );

  assign mem_addr       = pc_q;
  assign if_valid       = f_valid_q;
  assign if_pc          = f_pc_q;
  assign if_pc_plus4    = f_pc_q + 32'd4;
  assign misalign_fault = misalign_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage sitting directly upstream of instruction_memory. Owns the program counter and drives its readAddress. Pairs the synchronous (one-cycle-latency) instruction word coming back with the PC that produced it. Handles stall (skid hold), branch/jump redirect (with squash), and presents a valid-tagged instruction/PC pair to decode.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  rising-edge clock, shared with instruction_memory
rst_n  input  1  reset; synchronous, active-low
stall  input  1  decode not accepting; hold current output pair
redirect  input  1  taken branch/jump this cycle
redirect_target  input  32  byte address to fetch after redirect
mem_addr  output  32  to instruction_memory readAddress; equals pc register
mem_instr  input  32  instruction_memory instruction output (data for address sampled at previous edge)
if_valid  output  1  if_instr/if_pc hold a live instruction
if_instr  output  32  fetched instruction; 32'h0000_0000 when if_valid=0
if_pc  output  32  byte address of if_instr
if_pc_plus4  output  32  if_pc + 4, modulo 2^32
misalign_fault  output  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- State: pc (next fetch address), f_pc (address memory captured at last edge), f_valid, hold_instr, hold_valid, misalign_fault.
- Reset (rst_n=0 at edge): pc=RESET_PC, f_pc=RESET_PC, f_valid=0, hold_valid=0, hold_instr=0, misalign_fault=0. Outputs: if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, mem_addr=RESET_PC.
- Reset mid-operation squashes everything; no output may stay valid past the reset edge.
- Priority per edge: reset > redirect > stall > advance.
- Advance (no stall, no redirect): f_pc<=pc, f_valid<=1, pc<=pc+PC_STEP (wraps at 2^32), hold_valid<=0.
- Redirect, including while stalled:
  - pc<=redirect_target & ~32'h3, f_pc<=pc, f_valid<=0, hold_valid<=0.
  - Word fetched at this edge is discarded.
  - Target instruction is valid at if_* exactly 2 edges after the redirect cycle (one bubble).
  - misalign_fault<=|redirect_target[1:0]; otherwise misalign_fault<=0.
- Stall (no redirect): pc, f_pc, f_valid held.
  - Memory keeps reading mem[pc], so on the first stall edge hold_instr<=mem_instr and hold_valid<=f_valid.
  - Later stall edges hold hold_instr unchanged.
- Output mux: if_instr = !f_valid ? 0 : (hold_valid ? hold_instr : mem_instr); if_pc=f_pc; if_valid=f_valid.
- Stall release: next edge advances normally. Memory captures mem[pc], which is the instruction after f_pc, so there is no loss or duplication.
- Latency: reset release to first if_valid = 1 edge. Sequential throughput = 1 instruction/cycle.
- Stall with f_valid=0: hold_valid stays 0; if_valid stays 0.
- Address bits above [9:0] are passed through; instruction_memory wraps internally at 1024 bytes.

Decomposition:
- Package fetch_pkg: RESET_PC default, PC_STEP, NOP_INSTR=32'h0, ALIGN_MASK=32'hFFFF_FFFC.
- One natural sub-module: fetch_skid_hold (hold_instr/hold_valid capture plus output mux).
- PC/redirect logic stays in instruction_fetch.

Test Plan:
Bench loads instruction_memory with words 0x2149FF00@0, 0x2149FF04@4, 0x014B4808@8, 0x014B4812@12, 0x014B4816@16, 0x2149FF48@48.
1. Reset release, no stall: if_valid=1 one edge later with if_pc=0, if_instr=0x2149FF00. Next cycles give pc 4/8/12/16 with matching words; if_pc_plus4 tracks if_pc+4.
2. Stall for 3 cycles while if_pc=8: if_instr stays 0x014B4808 and if_pc stays 8 throughout. After release, next valid is pc=12 / 0x014B4812, with no duplicate.
3. Redirect to 0x30 while if_pc=4: next cycle if_valid=0, if_instr=0. Following cycle if_pc=0x30, if_instr=0x2149FF48, then if_pc=0x34.
4. Redirect to 0x32 concurrent with stall: redirect wins, hold cleared, misalign_fault pulses exactly 1 cycle, fetch resumes at 0x30.
5. rst_n low for 1 cycle during stall at if_pc=12: next cycle if_valid=0, if_pc=RESET_PC. Refetch yields 0x2149FF00.
6. Redirect to 0xFFFF_FFFC: if_pc=0xFFFF_FFFC, then if_pc=0x0000_0000 (wrap), with if_pc_plus4=0x0 at the first of these.
